imem_loader: RTL and testbench

- Writer side of the instruction memory that the PC/fetch logic reads at one 16-bit instruction per address.
- Accepts a byte stream over a valid/ready handshake (count byte, instruction bytes high-then-low, XOR checksum) and writes each assembled 16-bit instruction into instruction memory at consecutive addresses from 0.
- Keeps the CPU held off via cpu_hold until a load completes with a good checksum.

---
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction memory loader: receives a count/instruction/checksum byte stream and
// writes 16-bit words from address 0, holding the CPU until a load verifies.
module imem_loader #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] words_loaded
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_LO    = 3'd3;
    localparam logic [2:0] S_CHK   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]        state, state_n;
    logic [7:0]        chk, chk_n;
    logic [7:0]        hi, hi_n;
    logic [ADDR_W-1:0] remaining, remaining_n;
    logic [ADDR_W-1:0] imem_addr_n, words_loaded_n;
    logic [15:0]       imem_wdata_n;
    logic              in_ready_n, imem_we_n, cpu_hold_n, busy_n, done_n, err_n;
    logic              accept_c;

    // State and registered outputs; reset takes priority over any in-flight write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            chk          <= '0;
            hi           <= '0;
            remaining    <= '0;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_hold     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            state        <= state_n;
            chk          <= chk_n;
            hi           <= hi_n;
            remaining    <= remaining_n;
            in_ready     <= in_ready_n;
            imem_we      <= imem_we_n;
            imem_addr    <= imem_addr_n;
            imem_wdata   <= imem_wdata_n;
            cpu_hold     <= cpu_hold_n;
            busy         <= busy_n;
            done         <= done_n;
            err          <= err_n;
            words_loaded <= words_loaded_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n        = state;
        chk_n          = chk;
        hi_n           = hi;
        remaining_n    = remaining;
        imem_we_n      = 1'b0;
        imem_addr_n    = imem_addr;
        imem_wdata_n   = imem_wdata;
        cpu_hold_n     = cpu_hold;
        busy_n         = busy;
        done_n         = done;
        err_n          = err;
        words_loaded_n = words_loaded;
        accept_c       = in_valid && in_ready;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_n        = S_COUNT;
                    chk_n          = '0;
                    done_n         = 1'b0;
                    err_n          = 1'b0;
                    words_loaded_n = '0;
                    busy_n         = 1'b1;
                    cpu_hold_n     = 1'b1;
                end
            end
            S_COUNT: begin
                if (accept_c) begin
                    chk_n = chk ^ in_byte;
                    if (in_byte == 8'd0 || 32'(in_byte) > DEPTH) begin
                        state_n = S_ERR;
                        err_n   = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        remaining_n = ADDR_W'(in_byte);
                        state_n     = S_HI;
                    end
                end
            end
            S_HI: begin
                if (accept_c) begin
                    hi_n    = in_byte;
                    chk_n   = chk ^ in_byte;
                    state_n = S_LO;
                end
            end
            S_LO: begin
                if (accept_c) begin
                    chk_n          = chk ^ in_byte;
                    imem_wdata_n   = {hi, in_byte};
                    imem_addr_n    = words_loaded;
                    imem_we_n      = 1'b1;
                    words_loaded_n = words_loaded + ADDR_W'(1);
                    remaining_n    = remaining - ADDR_W'(1);
                    state_n        = (remaining == ADDR_W'(1)) ? S_CHK : S_HI;
                end
            end
            S_CHK: begin
                if (accept_c) begin
                    busy_n = 1'b0;
                    if (in_byte == chk) begin
                        state_n    = S_DONE;
                        done_n     = 1'b1;
                        cpu_hold_n = 1'b0;
                    end else begin
                        state_n = S_ERR;
                        err_n   = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        in_ready_n = (state_n == S_COUNT) || (state_n == S_HI) ||
                     (state_n == S_LO)    || (state_n == S_CHK);
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of load streams plus reset corner sequences.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_byte;
    logic        in_ready, imem_we, cpu_hold, busy, done, err;
    logic [7:0]  imem_addr, words_loaded;
    logic [15:0] imem_wdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
        .err(err), .words_loaded(words_loaded)
    );

    typedef struct {
        string              name;
        int                 n;
        logic [39:0][7:0]   b;
        bit                 gaps;
        logic               exp_done;
        logic               exp_err;
        int                 exp_words;
    } vec_t;

    vec_t vecs[7];

    logic [7:0]  wa_q[$];
    logic [15:0] wd_q[$];
    int          we_seen;

    // Write monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (imem_we) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
        end
        if (imem_we) we_seen++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("handshake_timeout", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (gap) repeat (2) @(posedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00; we_seen = 0;

        vecs[0] = '{name:"good2", n:6, b:'0, gaps:0, exp_done:1, exp_err:0, exp_words:2};
        vecs[0].b[5:0] = {8'h1B, 8'h41, 8'h1E, 8'h48, 8'h0E, 8'h02};
        vecs[1] = '{name:"badchk", n:6, b:'0, gaps:0, exp_done:0, exp_err:1, exp_words:2};
        vecs[1].b[5:0] = {8'h1C, 8'h41, 8'h1E, 8'h48, 8'h0E, 8'h02};
        vecs[2] = '{name:"count0", n:1, b:'0, gaps:0, exp_done:0, exp_err:1, exp_words:0};
        vecs[3] = '{name:"count17", n:1, b:'0, gaps:0, exp_done:0, exp_err:1, exp_words:0};
        vecs[3].b[0] = 8'h11;
        vecs[4] = '{name:"one_word", n:4, b:'0, gaps:0, exp_done:1, exp_err:0, exp_words:1};
        vecs[4].b[3:0] = {8'h01, 8'h00, 8'h00, 8'h01};
        vecs[5] = '{name:"good2_gaps", n:6, b:'0, gaps:1, exp_done:1, exp_err:0, exp_words:2};
        vecs[5].b[5:0] = {8'h1B, 8'h41, 8'h1E, 8'h48, 8'h0E, 8'h02};
        // 16 words 0000..000F; their XOR is 0, so the checksum is just the count.
        vecs[6] = '{name:"full16", n:34, b:'0, gaps:0, exp_done:1, exp_err:0, exp_words:16};
        vecs[6].b[0] = 8'h10;
        for (int i = 0; i < 16; i++) begin
            vecs[6].b[1 + 2*i] = 8'h00;
            vecs[6].b[2 + 2*i] = 8'(i);
        end
        vecs[6].b[33] = 8'h10;

        // Reset with in_valid held high.
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_no_we", 32'(we_seen), 32'd0);
        in_valid = 1'b0;

        for (int v = 0; v < 7; v++) begin
            wa_q.delete();
            wd_q.delete();
            pulse_start();
            check({vecs[v].name, "_busy_start"}, 32'(busy), 32'd1);
            for (int k = 0; k < vecs[v].n; k++) send_byte(vecs[v].b[k], vecs[v].gaps);
            repeat (2) @(negedge clk);
            check({vecs[v].name, "_done"}, 32'(done), 32'(vecs[v].exp_done));
            check({vecs[v].name, "_err"}, 32'(err), 32'(vecs[v].exp_err));
            check({vecs[v].name, "_hold"}, 32'(cpu_hold), 32'(!vecs[v].exp_done));
            check({vecs[v].name, "_busy"}, 32'(busy), 32'd0);
            check({vecs[v].name, "_in_ready"}, 32'(in_ready), 32'd0);
            check({vecs[v].name, "_words"}, 32'(words_loaded), 32'(vecs[v].exp_words));
            check({vecs[v].name, "_nwrites"}, 32'(wa_q.size()), 32'(vecs[v].exp_words));
            for (int i = 0; i < vecs[v].exp_words && i < wa_q.size(); i++) begin
                check({vecs[v].name, "_addr"}, 32'(wa_q[i]), 32'(i));
                check({vecs[v].name, "_data"}, 32'(wd_q[i]),
                      32'({vecs[v].b[1 + 2*i], vecs[v].b[2 + 2*i]}));
            end
        end

        // Reset coincident with the LO byte of word 1: only word 0 may be written.
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h0E, 0);
        send_byte(8'h48, 0);
        send_byte(8'h1E, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = 8'h41;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        check_reset_outputs("midrst");
        check("midrst_we", 32'(imem_we), 32'd0);
        repeat (3) @(negedge clk);
        check("midrst_nwrites", 32'(wa_q.size()), 32'd1);
        check("midrst_idle_ready", 32'(in_ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
